// File: rtl/cntry_road_vehicle_detector_pkg.sv
`default_nettype none
// ============================================================================
// Package  : traffic_pkg
// Purpose  : Shared types for the highway/country-road signal controller.
// Revision : 1.0
// ============================================================================
package traffic_pkg;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } signal_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVING = 2'd2,
    HOLDOFF = 2'd3
  } det_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cntry_road_vehicle_detector_loop_debounce.sv
`default_nettype none
// ============================================================================
// Module   : loop_debounce
// Purpose  : Synchronise and debounce one loop sensor; pulse on filtered rise.
// Revision : 1.0
// ============================================================================
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive synced samples that disagree with the filtered level.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        pulse_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/cntry_road_vehicle_detector.sv
`default_nettype none
// ============================================================================
// Module   : cntry_road_vehicle_detector
// Purpose  : Country-road loop front end: vehicle queue count and car request x.
// Revision : 1.0
// ============================================================================
module cntry_road_vehicle_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int QUEUE_W          = 4,
  parameter int MAX_GREEN_CYCLES = 32,
  parameter int HOLDOFF_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arr_sensor_raw,
  input  logic               dep_sensor_raw,
  input  logic [1:0]         cntry_road_signal,
  output logic               x,
  output logic [QUEUE_W-1:0] car_count,
  output logic [1:0]         det_state_out,
  output logic               count_err
);

  localparam int GT_W = cnt_width(MAX_GREEN_CYCLES);
  localparam int HT_W = cnt_width(HOLDOFF_CYCLES);
  localparam logic [GT_W-1:0]    GT_LAST = GT_W'(MAX_GREEN_CYCLES - 1);
  localparam logic [HT_W-1:0]    HT_LAST = HT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [QUEUE_W-1:0] CNT_MAX = '1;

  logic arr_ev, dep_ev;
  logic arr_level_unused, dep_level_unused;

  logic [QUEUE_W-1:0] car_count_q, car_count_d;
  logic               count_err_q, count_err_d;
  det_state_t         state_q, state_d;
  logic [GT_W-1:0]    green_timer_q, green_timer_d;
  logic [HT_W-1:0]    hold_timer_q, hold_timer_d;
  logic               x_q, x_d;

  logic is_green, is_red, cnt_nz;

  loop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arr_debounce (
    .clk        (clk),
    .reset      (reset),
    .raw        (arr_sensor_raw),
    .level      (arr_level_unused),
    .rise_pulse (arr_ev)
  );

  loop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dep_debounce (
    .clk        (clk),
    .reset      (reset),
    .raw        (dep_sensor_raw),
    .level      (dep_level_unused),
    .rise_pulse (dep_ev)
  );

  // Encoding 3 is not a legal aspect and is treated as red.
  assign is_green = (cntry_road_signal == green);
  assign is_red   = (cntry_road_signal != green) && (cntry_road_signal != yellow);
  assign cnt_nz   = (car_count_q != '0);

  always_comb begin
    car_count_d = car_count_q;
    count_err_d = count_err_q;
    if (arr_ev && !dep_ev) begin
      if (car_count_q == CNT_MAX) begin
        count_err_d = 1'b1;
      end else begin
        car_count_d = car_count_q + 1'b1;
      end
    end else if (dep_ev && !arr_ev) begin
      if (car_count_q == '0) begin
        count_err_d = 1'b1;
      end else begin
        car_count_d = car_count_q - 1'b1;
      end
    end
  end

  // Next-state logic; the hold timer only survives while in HOLDOFF.
  always_comb begin
    state_d       = state_q;
    green_timer_d = green_timer_q;
    hold_timer_d  = '0;
    case (state_q)
      IDLE: begin
        if (cnt_nz) state_d = REQUEST;
      end
      REQUEST: begin
        if (is_green) begin
          state_d       = SERVING;
          green_timer_d = '0;
        end else if (!cnt_nz) begin
          state_d = IDLE;
        end
      end
      SERVING: begin
        green_timer_d = green_timer_q + 1'b1;
        if (!cnt_nz || (green_timer_q == GT_LAST) || !is_green) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (is_red) begin
          if (hold_timer_q == HT_LAST) begin
            state_d = IDLE;
          end else begin
            hold_timer_d = hold_timer_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // x is registered from the next state so it never glitches on state decode.
  always_comb begin
    x_d = (state_d == REQUEST) || (state_d == SERVING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      green_timer_q <= '0;
      hold_timer_q  <= '0;
      x_q           <= 1'b0;
      car_count_q   <= '0;
      count_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      green_timer_q <= green_timer_d;
      hold_timer_q  <= hold_timer_d;
      x_q           <= x_d;
      car_count_q   <= car_count_d;
      count_err_q   <= count_err_d;
    end
  end

  assign x             = x_q;
  assign car_count     = car_count_q;
  assign det_state_out = state_q;
  assign count_err     = count_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cntry_road_vehicle_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cntry_road_vehicle_detector
// Purpose  : Directed scenarios plus randomized run against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_cntry_road_vehicle_detector;

  localparam int DEB  = 4;
  localparam int MAXG = 32;
  localparam int HOLD = 8;
  localparam int CMAX = 15;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       arr   = 1'b0;
  logic       dep   = 1'b0;
  logic [1:0] sig   = 2'd0;
  logic       x;
  logic [3:0] cc;
  logic [1:0] st;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  cntry_road_vehicle_detector dut (
    .clk               (clk),
    .reset             (reset),
    .arr_sensor_raw    (arr),
    .dep_sensor_raw    (dep),
    .cntry_road_signal (sig),
    .x                 (x),
    .car_count         (cc),
    .det_state_out     (st),
    .count_err         (err)
  );

  always #5 clk = ~clk;

  // Behavioural model, advanced once per clock from the inputs sampled at that edge.
  // Sensor history: index 0 is the newest raw sample; a filtered level flips when
  // the four samples seen through the two-stage synchroniser all disagree with it.
  int  m_st, m_cnt, m_gt, m_ht;
  bit  m_err;
  bit  ra[6];
  bit  rd[6];
  bit  fa, fd, pa, pd;

  function automatic bit window_flips(input bit h[6], input bit lvl);
    return (h[2] != lvl) && (h[3] != lvl) && (h[4] != lvl) && (h[5] != lvl);
  endfunction

  function automatic void model_step();
    bit grn, rd_sig, ea, ed, fl_a, fl_d;
    int nst;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_gt = 0; m_ht = 0; m_err = 0;
      fa = 0; fd = 0; pa = 0; pd = 0;
      for (int i = 0; i < 6; i++) begin ra[i] = 0; rd[i] = 0; end
      return;
    end
    grn    = (sig == 2'd2);
    rd_sig = (sig == 2'd0) || (sig == 2'd3);
    nst    = m_st;
    if (m_st == 0) begin
      if (m_cnt > 0) nst = 1;
    end else if (m_st == 1) begin
      if (grn) begin nst = 2; m_gt = 0; end
      else if (m_cnt == 0) nst = 0;
    end else if (m_st == 2) begin
      if (m_cnt == 0 || m_gt == MAXG - 1 || !grn) begin nst = 3; m_ht = 0; end
      else m_gt = m_gt + 1;
    end else begin
      if (!rd_sig) m_ht = 0;
      else if (m_ht == HOLD - 1) nst = 0;
      else m_ht = m_ht + 1;
    end
    m_st = nst;
    ea = pa; ed = pd;
    if (ea && !ed) begin
      if (m_cnt == CMAX) m_err = 1; else m_cnt = m_cnt + 1;
    end else if (ed && !ea) begin
      if (m_cnt == 0) m_err = 1; else m_cnt = m_cnt - 1;
    end
    for (int i = 5; i > 0; i--) begin ra[i] = ra[i-1]; rd[i] = rd[i-1]; end
    ra[0] = arr; rd[0] = dep;
    fl_a = window_flips(ra, fa);
    fl_d = window_flips(rd, fd);
    pa = fl_a && !fa;
    pd = fl_d && !fd;
    if (fl_a) fa = !fa;
    if (fl_d) fd = !fd;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic a, input logic d, input int hi, input int lo);
    arr = a; dep = d;
    step(hi);
    arr = 1'b0; dep = 1'b0;
    step(lo);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({x, cc, err, st} !== 8'b0) begin
      n_fail++; $display("FAIL reset_state: got %b want 00000000", {x, cc, err, st});
    end
    sig = 2'd0;
    pulse(1, 0, 6, 6);
    n_tests++;
    if ({x, cc} !== {1'b1, 4'd1}) begin
      n_fail++; $display("FAIL reset_precond: x/count got %b/%0d want 1/1", x, cc);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({x, cc, err, st} !== 8'b0) begin
      n_fail++; $display("FAIL reset_async: got %b want 00000000", {x, cc, err, st});
    end
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_debounce();
    do_reset();
    sig = 2'd0;
    pulse(1, 0, 3, 12);
    n_tests++;
    if ({cc, st} !== 6'b0) begin
      n_fail++; $display("FAIL short_pulse: count/state got %0d/%0d want 0/0", cc, st);
    end
    arr = 1'b1;
    step(6);
    arr = 1'b0;
    n_tests++;
    if (cc !== 4'd0) begin
      n_fail++; $display("FAIL arr_latency_early: count got %0d want 0", cc);
    end
    step(1);
    n_tests++;
    if ({x, cc} !== {1'b0, 4'd1}) begin
      n_fail++; $display("FAIL arr_latency_edge7: x/count got %b/%0d want 0/1", x, cc);
    end
    step(1);
    n_tests++;
    if ({x, st} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL request_raise: x/state got %b/%0d want 1/1", x, st);
    end
    step(10);
  endtask

  task automatic test_departures();
    pulse(1, 0, 6, 8);
    n_tests++;
    if ({x, cc, st} !== {1'b1, 4'd2, 2'd1}) begin
      n_fail++; $display("FAIL dep_precond: x/count/state got %b/%0d/%0d want 1/2/1", x, cc, st);
    end
    sig = 2'd2;
    dep = 1'b1;
    step(1);
    n_tests++;
    if ({x, st} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL serving_entry: x/state got %b/%0d want 1/2", x, st);
    end
    step(5);
    dep = 1'b0;
    step(6);
    n_tests++;
    if (cc !== 4'd1) begin
      n_fail++; $display("FAIL dep_first: count got %0d want 1", cc);
    end
    dep = 1'b1;
    step(6);
    dep = 1'b0;
    step(1);
    n_tests++;
    if ({x, cc, st} !== {1'b1, 4'd0, 2'd2}) begin
      n_fail++; $display("FAIL dep_second: x/count/state got %b/%0d/%0d want 1/0/2", x, cc, st);
    end
    step(1);
    n_tests++;
    if ({x, st} !== {1'b0, 2'd3}) begin
      n_fail++; $display("FAIL served_holdoff: x/state got %b/%0d want 0/3", x, st);
    end
  endtask

  task automatic test_max_green();
    bit ok;
    sig = 2'd0;
    pulse(1, 0, 6, 6);
    pulse(1, 0, 6, 6);
    pulse(1, 0, 6, 6);
    n_tests++;
    if ({x, cc, st} !== {1'b1, 4'd3, 2'd1}) begin
      n_fail++; $display("FAIL maxg_precond: x/count/state got %b/%0d/%0d want 1/3/1", x, cc, st);
    end
    sig = 2'd2;
    ok = 1;
    for (int k = 0; k < MAXG; k++) begin
      step(1);
      if ({x, st} !== {1'b1, 2'd2}) ok = 0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL maxg_window: x dropped early, now x/state %b/%0d want 1/2", x, st);
    end
    step(1);
    n_tests++;
    if ({x, st} !== {1'b0, 2'd3}) begin
      n_fail++; $display("FAIL maxg_cutoff: x/state got %b/%0d want 0/3", x, st);
    end
    sig = 2'd0;
    step(7);
    n_tests++;
    if ({x, st} !== {1'b0, 2'd3}) begin
      n_fail++; $display("FAIL holdoff_7red: x/state got %b/%0d want 0/3", x, st);
    end
    step(1);
    n_tests++;
    if ({x, st} !== {1'b0, 2'd0}) begin
      n_fail++; $display("FAIL holdoff_8red: x/state got %b/%0d want 0/0", x, st);
    end
    step(1);
    n_tests++;
    if ({x, st} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL rerequest: x/state got %b/%0d want 1/1", x, st);
    end
  endtask

  task automatic test_counter_limits();
    bit ok;
    sig = 2'd0;
    pulse(1, 0, 6, 6);
    pulse(1, 0, 6, 6);
    n_tests++;
    if (cc !== 4'd5) begin
      n_fail++; $display("FAIL lim_precond: count got %0d want 5", cc);
    end
    arr = 1'b1; dep = 1'b1;
    ok = 1;
    for (int k = 0; k < 14; k++) begin
      if (k == 6) begin arr = 1'b0; dep = 1'b0; end
      step(1);
      if (cc !== 4'd5) ok = 0;
    end
    n_tests++;
    if (!ok || err !== 1'b0) begin
      n_fail++; $display("FAIL simultaneous: count/err got %0d/%b want 5/0", cc, err);
    end
    for (int k = 0; k < 5; k++) pulse(0, 1, 6, 6);
    n_tests++;
    if ({cc, err} !== {4'd0, 1'b0}) begin
      n_fail++; $display("FAIL drain: count/err got %0d/%b want 0/0", cc, err);
    end
    pulse(0, 1, 6, 6);
    n_tests++;
    if ({cc, err} !== {4'd0, 1'b1}) begin
      n_fail++; $display("FAIL underflow: count/err got %0d/%b want 0/1", cc, err);
    end
    do_reset();
    for (int k = 0; k < 15; k++) pulse(1, 0, 6, 6);
    n_tests++;
    if ({cc, err} !== {4'd15, 1'b0}) begin
      n_fail++; $display("FAIL fill15: count/err got %0d/%b want 15/0", cc, err);
    end
    pulse(1, 0, 6, 6);
    n_tests++;
    if ({cc, err} !== {4'd15, 1'b1}) begin
      n_fail++; $display("FAIL saturate: count/err got %0d/%b want 15/1", cc, err);
    end
  endtask

  task automatic test_holdoff_yellow();
    bit ok;
    int budget;
    do_reset();
    sig = 2'd2;
    pulse(1, 0, 6, 6);
    pulse(0, 1, 6, 0);
    budget = 0;
    while (st !== 2'd3 && budget < 10) begin step(1); budget++; end
    n_tests++;
    if (st !== 2'd3) begin
      n_fail++; $display("FAIL holdoff_reach: state got %0d want 3", st);
    end
    sig = 2'd0;
    ok = 1;
    for (int k = 0; k < 13; k++) begin
      sig = (k == 5) ? 2'd1 : 2'd0;
      step(1);
      if ({x, st} !== {1'b0, 2'd3}) ok = 0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL holdoff_yellow_restart: left early, x/state %b/%0d want 0/3", x, st);
    end
    step(1);
    n_tests++;
    if ({x, st} !== {1'b0, 2'd0}) begin
      n_fail++; $display("FAIL holdoff_final: x/state got %b/%0d want 0/0", x, st);
    end
  endtask

  task automatic test_random();
    int a_left, d_left, s_left, shown;
    logic [7:0] exp_v;
    logic [1:0] sig_pick[6];
    sig_pick[0] = 2'd0; sig_pick[1] = 2'd2; sig_pick[2] = 2'd2;
    sig_pick[3] = 2'd0; sig_pick[4] = 2'd1; sig_pick[5] = 2'd3;
    do_reset();
    a_left = 0; d_left = 0; s_left = 0; shown = 0;
    for (int c = 0; c < 1500; c++) begin
      exp_v = {(m_st == 1 || m_st == 2) ? 1'b1 : 1'b0, m_cnt[3:0], m_err, m_st[1:0]};
      n_tests++;
      if ({x, cc, err, st} !== exp_v) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle_%0d: x,count,err,state got %b want %b", c, {x, cc, err, st}, exp_v);
        end
      end
      if (a_left == 0) begin
        arr = ($urandom_range(0, 2) == 0);
        a_left = $urandom_range(1, 9);
      end
      if (d_left == 0) begin
        dep = ($urandom_range(0, 2) == 0);
        d_left = $urandom_range(1, 9);
      end
      if (s_left == 0) begin
        sig = sig_pick[$urandom_range(0, 5)];
        s_left = $urandom_range(1, 40);
      end
      a_left--; d_left--; s_left--;
      step(1);
    end
    arr = 1'b0; dep = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_departures();
    test_max_green();
    test_counter_limits();
    test_holdoff_yellow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
